// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard scoreboard unit.
package hazard_pkg;

    localparam int DEFAULT_REG_ADDR_WIDTH = 5;
    localparam int DEFAULT_LONG_DEPTH     = 2;
    localparam int DEFAULT_PERF_WIDTH     = 32;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int DEFAULT_COUNT_WIDTH = count_width(DEFAULT_LONG_DEPTH);

    typedef struct packed {
        logic raw_execute;
        logic raw_memory;
        logic raw_long;
        logic waw_long;
        logic csr;
    } data_hazard_t;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-status and hazard-control bundle between the core and the hazard unit.
interface hazard_scoreboard_unit_if
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
    parameter int PERF_WIDTH     = DEFAULT_PERF_WIDTH
);

    logic [REG_ADDR_WIDTH-1:0] rs1_address_decode;
    logic [REG_ADDR_WIDTH-1:0] rs2_address_decode;
    logic [REG_ADDR_WIDTH-1:0] rd_address_decode;
    logic                      uses_rs1;
    logic                      uses_rs2;
    logic                      writes_rd_decode;
    logic                      uses_csr;
    logic [REG_ADDR_WIDTH-1:0] rd_address_execute;
    logic                      csr_write_execute;
    logic [REG_ADDR_WIDTH-1:0] rd_address_memory;
    logic                      csr_write_memory;
    logic                      bypass_memory;
    logic                      branch_taken;
    logic                      mret_memory;
    logic                      load_store;
    logic                      long_memory;
    logic [REG_ADDR_WIDTH-1:0] rd_address_writeback;
    logic                      csr_write_writeback;
    logic                      mret_writeback;
    logic                      wfi;
    logic                      traped;
    logic                      fetch_ready;
    logic                      mem_ready;
    logic                      long_done;
    logic [REG_ADDR_WIDTH-1:0] long_rd;

    logic                      long_dispatch;
    logic                      long_grant;
    logic                      stall_fetch;
    logic                      invalidate_fetch;
    logic                      stall_decode;
    logic                      invalidate_decode;
    logic                      stall_execute;
    logic                      invalidate_execute;
    logic                      stall_memory;
    logic                      invalidate_memory;
    logic                      stall_writeback;
    logic [PERF_WIDTH-1:0]     perf_data_stall;
    logic [PERF_WIDTH-1:0]     perf_long_stall;
    logic [PERF_WIDTH-1:0]     perf_mem_stall;

    modport master (
        output rs1_address_decode, rs2_address_decode, rd_address_decode,
        output uses_rs1, uses_rs2, writes_rd_decode, uses_csr,
        output rd_address_execute, csr_write_execute,
        output rd_address_memory, csr_write_memory, bypass_memory, branch_taken,
        output mret_memory, load_store, long_memory,
        output rd_address_writeback, csr_write_writeback, mret_writeback, wfi, traped,
        output fetch_ready, mem_ready, long_done, long_rd,
        input  long_dispatch, long_grant,
        input  stall_fetch, invalidate_fetch, stall_decode, invalidate_decode,
        input  stall_execute, invalidate_execute, stall_memory, invalidate_memory,
        input  stall_writeback,
        input  perf_data_stall, perf_long_stall, perf_mem_stall
    );

    modport slave (
        input  rs1_address_decode, rs2_address_decode, rd_address_decode,
        input  uses_rs1, uses_rs2, writes_rd_decode, uses_csr,
        input  rd_address_execute, csr_write_execute,
        input  rd_address_memory, csr_write_memory, bypass_memory, branch_taken,
        input  mret_memory, load_store, long_memory,
        input  rd_address_writeback, csr_write_writeback, mret_writeback, wfi, traped,
        input  fetch_ready, mem_ready, long_done, long_rd,
        output long_dispatch, long_grant,
        output stall_fetch, invalidate_fetch, stall_decode, invalidate_decode,
        output stall_execute, invalidate_execute, stall_memory, invalidate_memory,
        output stall_writeback,
        output perf_data_stall, perf_long_stall, perf_mem_stall
    );

endinterface

// File: rtl/hazard_scoreboard_unit_pending_scoreboard.sv
// Per-register pending bits for in-flight long ops plus the outstanding-op count.
module pending_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
    parameter int LONG_DEPTH     = DEFAULT_LONG_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      dispatch_i,
    input  logic [REG_ADDR_WIDTH-1:0] set_addr_i,
    input  logic                      grant_i,
    input  logic [REG_ADDR_WIDTH-1:0] clr_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [REG_ADDR_WIDTH-1:0] mem_addr_i,
    output logic                      pend_rs1_o,
    output logic                      pend_rs2_o,
    output logic                      pend_rd_o,
    output logic                      pend_mem_o,
    output logic                      full_o
);

    localparam int REG_COUNT   = 2 ** REG_ADDR_WIDTH;
    localparam int COUNT_WIDTH = count_width(LONG_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(LONG_DEPTH);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    logic [REG_COUNT-1:0]   pending_q, pending_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        pending_d = pending_q;
        count_d   = count_q;
        // Clear before set so a same-cycle set on the same index wins.
        if (grant_i) begin
            pending_d[clr_addr_i] = 1'b0;
        end
        if (dispatch_i) begin
            pending_d[set_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;

        if (dispatch_i && !grant_i) begin
            count_d = count_q + COUNT_ONE;
        end else if (grant_i && !dispatch_i && count_q != '0) begin
            count_d = count_q - COUNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
        if (reset) begin
            // NOTE: the pending vector is a flag array, not a RAM, so it is reset; stale bits would fake hazards.
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign pend_rs1_o = pending_q[rs1_addr_i];
    assign pend_rs2_o = pending_q[rs2_addr_i];
    assign pend_rd_o  = pending_q[rd_addr_i];
    assign pend_mem_o = pending_q[mem_addr_i];
    assign full_o     = (count_q == COUNT_MAX);

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Five-stage stall/invalidate network with long-op scoreboard and write-port arbitration.
// Optional stall-cycle performance counters are built when HAZARD_PERF_EN is defined.
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEFAULT_REG_ADDR_WIDTH,
    parameter int LONG_DEPTH     = DEFAULT_LONG_DEPTH,
    parameter int PERF_WIDTH     = DEFAULT_PERF_WIDTH
) (
    input logic                     clk,
    input logic                     reset,
    hazard_scoreboard_unit_if.slave hz
);

    logic         trap_inv;
    logic         branch_inv;
    logic         mem_wait;
    logic         data_hazard;
    logic         long_block;
    logic         pend_rs1, pend_rs2, pend_rd, pend_mem, sb_full;
    data_hazard_t hazard;

    assign trap_inv   = hz.mret_writeback || hz.traped;
    assign branch_inv = hz.branch_taken || trap_inv;
    assign mem_wait   = !hz.mem_ready && hz.load_store;

    assign hazard.raw_execute = (hz.rd_address_execute != '0) &&
        ((hz.uses_rs1 && hz.rs1_address_decode == hz.rd_address_execute) ||
         (hz.uses_rs2 && hz.rs2_address_decode == hz.rd_address_execute));
    // Long ops leave memory with bypass_memory low, so this also covers the dispatch gap.
    assign hazard.raw_memory  = (hz.rd_address_memory != '0) && !hz.bypass_memory &&
        ((hz.uses_rs1 && hz.rs1_address_decode == hz.rd_address_memory) ||
         (hz.uses_rs2 && hz.rs2_address_decode == hz.rd_address_memory));
    assign hazard.raw_long    = (pend_rs1 && hz.uses_rs1) || (pend_rs2 && hz.uses_rs2);
    assign hazard.waw_long    = hz.writes_rd_decode && pend_rd;
    assign hazard.csr         = hz.uses_csr &&
        (hz.csr_write_execute || hz.csr_write_memory || hz.csr_write_writeback);
    assign data_hazard        = |hazard;

    pending_scoreboard #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .LONG_DEPTH     (LONG_DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .dispatch_i (hz.long_dispatch),
        .set_addr_i (hz.rd_address_memory),
        .grant_i    (hz.long_grant),
        .clr_addr_i (hz.long_rd),
        .rs1_addr_i (hz.rs1_address_decode),
        .rs2_addr_i (hz.rs2_address_decode),
        .rd_addr_i  (hz.rd_address_decode),
        .mem_addr_i (hz.rd_address_memory),
        .pend_rs1_o (pend_rs1),
        .pend_rs2_o (pend_rs2),
        .pend_rd_o  (pend_rd),
        .pend_mem_o (pend_mem),
        .full_o     (sb_full)
    );

    assign long_block = hz.long_memory &&
        (sb_full || (hz.rd_address_memory != '0 && pend_mem));

    assign hz.invalidate_execute = reset || branch_inv;
    assign hz.invalidate_memory  = reset || trap_inv || mem_wait;
    assign hz.invalidate_decode  = reset || branch_inv || data_hazard;
    assign hz.invalidate_fetch   = reset || branch_inv || (!hz.fetch_ready && !hz.invalidate_decode);

    // Long completion owns the write port; writeback waits unless a trap flushes it anyway.
    assign hz.long_grant      = hz.long_done;
    assign hz.stall_writeback = !reset && hz.long_grant &&
        (hz.rd_address_writeback != '0) && !trap_inv;
    assign hz.stall_memory    = !hz.invalidate_memory &&
        (hz.stall_writeback || hz.wfi || long_block);
    assign hz.stall_execute   = !hz.invalidate_execute &&
        (hz.stall_memory || hz.invalidate_memory || mem_wait || hz.mret_memory);
    assign hz.stall_decode    = !hz.invalidate_decode &&
        (hz.stall_execute || hz.invalidate_execute);
    assign hz.stall_fetch     = !hz.invalidate_fetch &&
        (hz.stall_decode || hz.invalidate_decode);

    assign hz.long_dispatch = hz.long_memory && !long_block &&
        !hz.stall_memory && !hz.invalidate_memory;

`ifdef HAZARD_PERF_EN
    logic [PERF_WIDTH-1:0] perf_data_q, perf_long_q, perf_mem_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_data_q <= '0;
            perf_long_q <= '0;
            perf_mem_q  <= '0;
        end else begin
            perf_data_q <= perf_data_q + PERF_WIDTH'(data_hazard);
            perf_long_q <= perf_long_q + PERF_WIDTH'(long_block && hz.long_memory);
            perf_mem_q  <= perf_mem_q + PERF_WIDTH'(mem_wait);
        end
    end

    assign hz.perf_data_stall = perf_data_q;
    assign hz.perf_long_stall = perf_long_q;
    assign hz.perf_mem_stall  = perf_mem_q;
`else
    assign hz.perf_data_stall = '0;
    assign hz.perf_long_stall = '0;
    assign hz.perf_mem_stall  = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench: directed hazard scenarios plus randomized traffic against a behavioural model.
module tb_hazard_scoreboard_unit;

    localparam int RAW = 5;
    localparam int LD  = 2;
    localparam int PW  = 32;

    logic clk = 1'b0;
    logic reset;

    hazard_scoreboard_unit_if #(.REG_ADDR_WIDTH(RAW), .PERF_WIDTH(PW)) hif ();

    hazard_scoreboard_unit #(
        .REG_ADDR_WIDTH (RAW),
        .LONG_DEPTH     (LD),
        .PERF_WIDTH     (PW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state: which registers a long op still owes, and the ops in flight in order.
    bit          pend_m [32];
    int          cnt_m;
    int          inflight [$];
    logic [PW-1:0] m_perf_data, m_perf_long, m_perf_mem;

    bit e_inv_f, e_inv_d, e_inv_e, e_inv_m;
    bit e_st_f, e_st_d, e_st_e, e_st_m, e_st_w;
    bit e_disp, e_grant, e_block, e_data, e_memwait;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        hif.rs1_address_decode   = '0;
        hif.rs2_address_decode   = '0;
        hif.rd_address_decode    = '0;
        hif.uses_rs1             = 1'b0;
        hif.uses_rs2             = 1'b0;
        hif.writes_rd_decode     = 1'b0;
        hif.uses_csr             = 1'b0;
        hif.rd_address_execute   = '0;
        hif.csr_write_execute    = 1'b0;
        hif.rd_address_memory    = '0;
        hif.csr_write_memory     = 1'b0;
        hif.bypass_memory        = 1'b0;
        hif.branch_taken         = 1'b0;
        hif.mret_memory          = 1'b0;
        hif.load_store           = 1'b0;
        hif.long_memory          = 1'b0;
        hif.rd_address_writeback = '0;
        hif.csr_write_writeback  = 1'b0;
        hif.mret_writeback       = 1'b0;
        hif.wfi                  = 1'b0;
        hif.traped               = 1'b0;
        hif.fetch_ready          = 1'b1;
        hif.mem_ready            = 1'b1;
        hif.long_done            = 1'b0;
        hif.long_rd              = '0;
    endtask

    task automatic compute_expected();
        int reads [$];
        bit trap, br;
        trap = hif.mret_writeback || hif.traped;
        br   = hif.branch_taken || trap;
        if (hif.uses_rs1) reads.push_back(int'(hif.rs1_address_decode));
        if (hif.uses_rs2) reads.push_back(int'(hif.rs2_address_decode));
        e_data = 1'b0;
        foreach (reads[i]) begin
            if (hif.rd_address_execute != 0 && reads[i] == int'(hif.rd_address_execute)) e_data = 1'b1;
            if (hif.rd_address_memory != 0 && !hif.bypass_memory &&
                reads[i] == int'(hif.rd_address_memory)) e_data = 1'b1;
            if (pend_m[reads[i]]) e_data = 1'b1;
        end
        if (hif.writes_rd_decode && pend_m[hif.rd_address_decode]) e_data = 1'b1;
        if (hif.uses_csr && (hif.csr_write_execute || hif.csr_write_memory || hif.csr_write_writeback))
            e_data = 1'b1;

        e_memwait = !hif.mem_ready && hif.load_store;
        e_inv_d   = reset || br || e_data;
        e_inv_f   = reset || br || (!hif.fetch_ready && !e_inv_d);
        e_inv_e   = reset || br;
        e_inv_m   = reset || trap || e_memwait;
        e_block   = hif.long_memory &&
                    (cnt_m == LD || (hif.rd_address_memory != 0 && pend_m[hif.rd_address_memory]));
        e_grant   = hif.long_done;
        e_st_w    = !reset && e_grant && hif.rd_address_writeback != 0 && !trap;
        e_st_m    = !e_inv_m && (e_st_w || hif.wfi || e_block);
        e_st_e    = !e_inv_e && (e_st_m || e_inv_m || e_memwait || hif.mret_memory);
        e_st_d    = !e_inv_d && (e_st_e || e_inv_e);
        e_st_f    = !e_inv_f && (e_st_d || e_inv_d);
        e_disp    = hif.long_memory && !e_block && !e_st_m && !e_inv_m;
    endtask

    task automatic compare_outputs();
        logic [PW-1:0] ep_data, ep_long, ep_mem;
        compute_expected();
`ifdef HAZARD_PERF_EN
        ep_data = m_perf_data;
        ep_long = m_perf_long;
        ep_mem  = m_perf_mem;
`else
        ep_data = '0;
        ep_long = '0;
        ep_mem  = '0;
`endif
        check("invalidate_fetch",   64'(hif.invalidate_fetch),   64'(e_inv_f));
        check("invalidate_decode",  64'(hif.invalidate_decode),  64'(e_inv_d));
        check("invalidate_execute", 64'(hif.invalidate_execute), 64'(e_inv_e));
        check("invalidate_memory",  64'(hif.invalidate_memory),  64'(e_inv_m));
        check("stall_fetch",        64'(hif.stall_fetch),        64'(e_st_f));
        check("stall_decode",       64'(hif.stall_decode),       64'(e_st_d));
        check("stall_execute",      64'(hif.stall_execute),      64'(e_st_e));
        check("stall_memory",       64'(hif.stall_memory),       64'(e_st_m));
        check("stall_writeback",    64'(hif.stall_writeback),    64'(e_st_w));
        check("long_dispatch",      64'(hif.long_dispatch),      64'(e_disp));
        check("long_grant",         64'(hif.long_grant),         64'(e_grant));
        check("perf_data_stall",    64'(hif.perf_data_stall),    64'(ep_data));
        check("perf_long_stall",    64'(hif.perf_long_stall),    64'(ep_long));
        check("perf_mem_stall",     64'(hif.perf_mem_stall),     64'(ep_mem));
    endtask

    task automatic update_model();
        if (reset) begin
            foreach (pend_m[i]) pend_m[i] = 1'b0;
            cnt_m = 0;
            inflight.delete();
            m_perf_data = '0;
            m_perf_long = '0;
            m_perf_mem  = '0;
        end else begin
            assert (!e_grant || cnt_m > 0)
                else $error("protocol: long_done driven with no long op outstanding");
            if (e_grant) begin
                pend_m[hif.long_rd] = 1'b0;
                if (inflight.size() > 0) void'(inflight.pop_front());
            end
            if (e_disp) begin
                pend_m[hif.rd_address_memory] = 1'b1;
                inflight.push_back(int'(hif.rd_address_memory));
            end
            pend_m[0] = 1'b0;
            cnt_m = cnt_m + (e_disp ? 1 : 0) - ((e_grant && cnt_m > 0) ? 1 : 0);
            if (e_data)    m_perf_data = m_perf_data + 1'b1;
            if (e_block)   m_perf_long = m_perf_long + 1'b1;
            if (e_memwait) m_perf_mem  = m_perf_mem + 1'b1;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic advance();
        update_model();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic long_mem(input int rd);
        hif.long_memory       = 1'b1;
        hif.rd_address_memory = RAW'(rd);
    endtask

    task automatic grant(input int rd);
        idle_inputs();
        hif.long_done = 1'b1;
        hif.long_rd   = RAW'(rd);
        cycle();
    endtask

    initial begin
        foreach (pend_m[i]) pend_m[i] = 1'b0;
        cnt_m = 0;
        m_perf_data = '0;
        m_perf_long = '0;
        m_perf_mem  = '0;
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;

        // Reset state: everything invalidated, nothing stalled or dispatched, grant follows done.
        hif.long_memory = 1'b1;
        hif.long_done   = 1'b1;
        settle();
        check("rst_inv_fetch",  64'(hif.invalidate_fetch),   64'd1);
        check("rst_inv_decode", 64'(hif.invalidate_decode),  64'd1);
        check("rst_inv_exec",   64'(hif.invalidate_execute), 64'd1);
        check("rst_inv_mem",    64'(hif.invalidate_memory),  64'd1);
        check("rst_stall_mem",  64'(hif.stall_memory),       64'd0);
        check("rst_dispatch",   64'(hif.long_dispatch),      64'd0);
        check("rst_grant",      64'(hif.long_grant),         64'd1);
        advance();
        reset = 1'b0;
        idle_inputs();
        settle();
        check("post_rst_perf_data", 64'(hif.perf_data_stall), 64'd0);
        check("post_rst_stall_fetch", 64'(hif.stall_fetch), 64'd0);
        advance();

        // RAW on a long-op destination holds decode until the cycle after grant.
        idle_inputs(); long_mem(5);
        settle(); check("t1_dispatch", 64'(hif.long_dispatch), 64'd1); advance();
        idle_inputs(); hif.uses_rs1 = 1'b1; hif.rs1_address_decode = 5'd5;
        settle(); check("t1_raw_wait0", 64'(hif.invalidate_decode), 64'd1); advance();
        settle(); check("t1_raw_wait1", 64'(hif.invalidate_decode), 64'd1); advance();
        hif.long_done = 1'b1; hif.long_rd = 5'd5;
        settle();
        check("t1_grant", 64'(hif.long_grant), 64'd1);
        check("t1_raw_in_grant", 64'(hif.invalidate_decode), 64'd1);
        advance();
        hif.long_done = 1'b0;
        settle(); check("t1_raw_released", 64'(hif.invalidate_decode), 64'd0); advance();

        // Depth limit: third long op waits until the cycle after the first grant.
        idle_inputs(); long_mem(1); cycle();
        idle_inputs(); long_mem(2); cycle();
        idle_inputs(); long_mem(4);
        settle();
        check("t2_full_dispatch", 64'(hif.long_dispatch), 64'd0);
        check("t2_full_stall_ex", 64'(hif.stall_execute), 64'd1);
        advance();
        hif.long_done = 1'b1; hif.long_rd = 5'd1;
        settle(); check("t2_grant_cycle_dispatch", 64'(hif.long_dispatch), 64'd0); advance();
        hif.long_done = 1'b0;
        settle(); check("t2_after_grant_dispatch", 64'(hif.long_dispatch), 64'd1); advance();
        grant(2);
        grant(4);

        // Long completion takes the write port from writeback rd=7.
        idle_inputs(); long_mem(9); cycle();
        idle_inputs(); hif.long_done = 1'b1; hif.long_rd = 5'd9; hif.rd_address_writeback = 5'd7;
        settle();
        check("t3_grant",     64'(hif.long_grant),      64'd1);
        check("t3_stall_wb",  64'(hif.stall_writeback), 64'd1);
        check("t3_stall_mem", 64'(hif.stall_memory),    64'd1);
        advance();
        hif.long_done = 1'b0;
        settle(); check("t3_wb_proceeds", 64'(hif.stall_writeback), 64'd0); advance();

        // WAW against a pending long-op destination.
        idle_inputs(); long_mem(3); cycle();
        idle_inputs(); hif.writes_rd_decode = 1'b1; hif.rd_address_decode = 5'd3;
        settle(); check("t4_waw", 64'(hif.invalidate_decode), 64'd1); advance();
        hif.long_done = 1'b1; hif.long_rd = 5'd3;
        settle(); check("t4_waw_in_grant", 64'(hif.invalidate_decode), 64'd1); advance();
        hif.long_done = 1'b0;
        settle(); check("t4_waw_released", 64'(hif.invalidate_decode), 64'd0); advance();

        // A trap alongside long_memory blocks dispatch and leaves the count alone.
        idle_inputs(); long_mem(6); cycle();
        idle_inputs(); long_mem(10); hif.traped = 1'b1;
        settle();
        check("t5_trap_dispatch", 64'(hif.long_dispatch),     64'd0);
        check("t5_trap_inv_mem",  64'(hif.invalidate_memory), 64'd1);
        advance();
        idle_inputs(); long_mem(11);
        settle(); check("t5_count_unchanged", 64'(hif.long_dispatch), 64'd1); advance();
        idle_inputs(); long_mem(12);
        settle(); check("t5_now_full", 64'(hif.long_dispatch), 64'd0); advance();
        idle_inputs(); hif.uses_rs1 = 1'b1; hif.rs1_address_decode = 5'd10;
        settle(); check("t5_no_pending10", 64'(hif.invalidate_decode), 64'd0); advance();
        grant(6);
        grant(11);

        // Reset with two ops outstanding discards them.
        idle_inputs(); long_mem(13); cycle();
        idle_inputs(); long_mem(14); cycle();
        idle_inputs(); reset = 1'b1; long_mem(15); hif.long_done = 1'b1; hif.long_rd = 5'd13;
        settle();
        check("t6_rst_dispatch", 64'(hif.long_dispatch), 64'd0);
        check("t6_rst_stall_wb", 64'(hif.stall_writeback), 64'd0);
        advance();
        reset = 1'b0; idle_inputs();
        hif.uses_rs1 = 1'b1; hif.rs1_address_decode = 5'd13;
        hif.uses_rs2 = 1'b1; hif.rs2_address_decode = 5'd14;
        settle();
        check("t6_pending_cleared", 64'(hif.invalidate_decode), 64'd0);
        check("t6_perf_data", 64'(hif.perf_data_stall), 64'd0);
        check("t6_perf_long", 64'(hif.perf_long_stall), 64'd0);
        check("t6_perf_mem",  64'(hif.perf_mem_stall),  64'd0);
        advance();
        idle_inputs(); long_mem(15);
        settle(); check("t6_count_cleared0", 64'(hif.long_dispatch), 64'd1); advance();
        idle_inputs(); long_mem(16);
        settle(); check("t6_count_cleared1", 64'(hif.long_dispatch), 64'd1); advance();
        grant(15);
        grant(16);

        // Randomized traffic, every cycle checked against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            hif.rs1_address_decode   = RAW'($urandom_range(0, 7));
            hif.rs2_address_decode   = RAW'($urandom_range(0, 7));
            hif.rd_address_decode    = RAW'($urandom_range(0, 7));
            hif.uses_rs1             = 1'($urandom_range(0, 1));
            hif.uses_rs2             = 1'($urandom_range(0, 1));
            hif.writes_rd_decode     = 1'($urandom_range(0, 1));
            hif.uses_csr             = ($urandom_range(0, 99) < 15);
            hif.rd_address_execute   = RAW'($urandom_range(0, 7));
            hif.csr_write_execute    = ($urandom_range(0, 99) < 10);
            hif.rd_address_memory    = RAW'($urandom_range(0, 7));
            hif.csr_write_memory     = ($urandom_range(0, 99) < 10);
            hif.bypass_memory        = 1'($urandom_range(0, 1));
            hif.branch_taken         = ($urandom_range(0, 99) < 5);
            hif.mret_memory          = ($urandom_range(0, 99) < 5);
            hif.load_store           = ($urandom_range(0, 99) < 30);
            hif.long_memory          = ($urandom_range(0, 99) < 35);
            hif.rd_address_writeback = RAW'($urandom_range(0, 7));
            hif.csr_write_writeback  = ($urandom_range(0, 99) < 10);
            hif.mret_writeback       = ($urandom_range(0, 99) < 2);
            hif.wfi                  = ($urandom_range(0, 99) < 3);
            hif.traped               = ($urandom_range(0, 99) < 3);
            hif.fetch_ready          = ($urandom_range(0, 99) < 85);
            hif.mem_ready            = ($urandom_range(0, 99) < 80);
            if (inflight.size() > 0 && $urandom_range(0, 99) < 40) begin
                hif.long_done = 1'b1;
                hif.long_rd   = RAW'(inflight[0]);
            end else begin
                hif.long_done = 1'b0;
                hif.long_rd   = '0;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard_unit.md
# hazard_scoreboard_unit

Pipeline hazard controller for the five-stage core. It generates stall and invalidate signals for fetch, decode, execute, memory and writeback. It also tracks long-latency operations (mul/div) that leave the memory stage and complete out of band, using a per-register pending scoreboard. It is parametrised in register address width and long-op depth, and it arbitrates the register-file write port between writeback and long-op completion.

## Interface
Parameters:
- REG_ADDR_WIDTH, 5, register address width; REG_COUNT = 2**REG_ADDR_WIDTH
- LONG_DEPTH, 2, maximum long ops in flight (1..7)
- PERF_WIDTH, 32, width of each performance counter

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- rs1_address_decode, rs2_address_decode, rd_address_decode  in  REG_ADDR_WIDTH  decode register addresses
- uses_rs1, uses_rs2, writes_rd_decode, uses_csr  in  1  decode operand usage
- rd_address_execute  in  REG_ADDR_WIDTH  execute destination; 0 = none
- csr_write_execute  in  1  CSR write pending in execute
- rd_address_memory  in  REG_ADDR_WIDTH  memory destination; 0 = none
- csr_write_memory, bypass_memory, branch_taken, mret_memory, load_store  in  1  memory-stage status
- long_memory  in  1  memory stage holds a long op awaiting dispatch
- rd_address_writeback  in  REG_ADDR_WIDTH  writeback destination; 0 = none
- csr_write_writeback, mret_writeback, wfi, traped  in  1  writeback status
- fetch_ready, mem_ready  in  1  bus handshakes
- long_done  in  1  long unit has a result
- long_rd  in  REG_ADDR_WIDTH  destination of that result
- long_dispatch  out  1  long op accepted this cycle
- long_grant  out  1  long result owns the register-file write port this cycle
- stall_fetch, invalidate_fetch, stall_decode, invalidate_decode, stall_execute, invalidate_execute, stall_memory, invalidate_memory, stall_writeback  out  1
- perf_data_stall, perf_long_stall, perf_mem_stall  out  PERF_WIDTH  stall-cycle counters

## Operation
- Stall chaining:
  - stall_X = !invalidate_X && (stall_next || invalidate_next || local cause).
  - Local cause for memory: wfi || long_block || stall_writeback.
  - Local cause for execute: (!mem_ready && load_store) || mret_memory.
- Invalidate base conditions:
  - trap_inv = mret_writeback || traped.
  - branch_inv = branch_taken || trap_inv.
  - invalidate_fetch = reset || branch_inv || (!fetch_ready && !invalidate_decode).
  - invalidate_execute = reset || branch_inv.
  - invalidate_memory = reset || trap_inv || (!mem_ready && load_store).
- invalidate_decode = reset || branch_inv, or any of the following:
  - RAW against execute: rd_address_execute ≠ 0 and matches a used rs.
  - RAW against memory: rd_address_memory ≠ 0, !bypass_memory, and matches a used rs.
  - RAW against long ops: pending[rs1] && uses_rs1, or pending[rs2] && uses_rs2.
  - WAW against long ops: writes_rd_decode && pending[rd_address_decode].
  - CSR: uses_csr and any CSR write in execute, memory or writeback.
- Long ops drive bypass_memory=0, so dependents never forward from them.
- Dispatch:
  - long_block = long_memory && (count == LONG_DEPTH || (rd_address_memory ≠ 0 && pending[rd_address_memory])).
  - long_dispatch = long_memory && !long_block && !stall_memory && !invalidate_memory.
  - After dispatch, the memory stage passes the op on with rd cleared.
- Grant:
  - long_grant = long_done. Long completion has priority over writeback.
  - stall_writeback = long_grant && rd_address_writeback ≠ 0 && !trap_inv.
  - The long unit holds long_done/long_rd until it sees long_grant.
- Scoreboard update:
  - On long_dispatch with rd ≠ 0: pending[rd_address_memory] ← 1.
  - On long_grant: pending[long_rd] ← 0.
  - If the same index is set and cleared in one cycle, set wins.
  - pending[0] is always 0.
- Outstanding count (0..LONG_DEPTH): +1 on dispatch, −1 on grant, unchanged when both occur.
- A grant with count 0 is a protocol error: count stays 0 (assertion in bench).

## Timing
- All stall/invalidate/dispatch/grant outputs are combinational from inputs and registered state, valid in the same cycle.
- Scoreboard and count update on the rising clk edge.
  - A pending bit is visible to decode the cycle after dispatch.
  - While the op sits in memory, the rd_address_memory comparison covers that gap.
  - A pending bit clears the cycle after grant, so a dependent reads the register file no earlier than grant+1.
- Reset: pending all 0, count 0, perf counters 0. While reset is high, every invalidate is 1, every stall is 0, and long_dispatch=0. long_grant follows long_done; the long unit is reset in the same cycle.
- Reset mid-operation discards all in-flight long ops.
- A trap in the same cycle as long_memory: invalidate_memory blocks dispatch.

## Configuration
- HAZARD_PERF_EN defined: each counter increments by 1 per cycle, wrapping at 2**PERF_WIDTH.
  - perf_data_stall: invalidate_decode from a RAW/WAW/CSR term (not from reset or branch).
  - perf_long_stall: long_block && long_memory.
  - perf_mem_stall: !mem_ready && load_store.
- HAZARD_PERF_EN undefined: counters are not built; the perf ports are tied to 0.

## Structure
- Shared package hazard_pkg holds:
  - the default REG_ADDR_WIDTH, LONG_DEPTH and PERF_WIDTH;
  - the count width, computed as clog2(LONG_DEPTH+1).
- Sub-module pending_scoreboard: the pending bit vector plus outstanding count. It has set/clear ports and three read ports (rs1, rs2, rd) plus a rd_address_memory lookup.
- The top level holds the combinational stall/invalidate network and the perf counters.

## Test plan
- Dispatch long op rd=5, then a decode instruction with rs1=5 -> invalidate_decode=1 every cycle until long_grant; invalidate_decode drops to 0 the cycle after grant.
- LONG_DEPTH=2 with two dispatches outstanding, and a third long_memory -> long_dispatch=0, stall_execute=1; dispatch occurs in the cycle after the first grant.
- long_done in the same cycle as writeback rd=7 -> long_grant=1, stall_writeback=1, stall_memory=1; writeback proceeds the next cycle.
- Long op rd=3 pending, decode writes_rd_decode with rd=3 and no reads -> WAW bubble until pending[3] clears.
- traped=1 in the same cycle as long_memory -> long_dispatch=0, count unchanged, invalidate_memory=1.
- reset asserted with 2 outstanding -> next cycle count=0, pending=0, and with HAZARD_PERF_EN all counters are 0.
